// File: rtl/mem_bus_ctrl_pkg.sv
// mem_bus_ctrl_pkg: shared types for the local-bus cycle controller.
// Bus states are one-hot; S_* give each state's bit position.
package mem_bus_ctrl_pkg;

  localparam int S_T1 = 0;
  localparam int S_T2 = 1;
  localparam int S_TW = 2;
  localparam int S_T3 = 3;
  localparam int S_T4 = 4;

  typedef enum logic [4:0] {
    T1 = 5'b00001,
    T2 = 5'b00010,
    TW = 5'b00100,
    T3 = 5'b01000,
    T4 = 5'b10000
  } state_t;

  typedef enum logic {
    DIR_READ  = 1'b0,
    DIR_WRITE = 1'b1
  } dir_t;

  localparam logic DEF_VALID_IOM = 1'b0;

endpackage

// File: rtl/mem_bus_ctrl_cs_decoder.sv
// cs_decoder: turns the chip-select vector into a bank index.
// It also flags exactly-one and more-than-one selects.
module cs_decoder
  import mem_bus_ctrl_pkg::*;
#(
  parameter int N_BANKS = 4,
  localparam int BW = $clog2(N_BANKS),
  localparam int CW = $clog2(N_BANKS + 1)
) (
  input  logic [N_BANKS-1:0] cs,
  output logic [BW-1:0]      idx,
  output logic               onehot_ok,
  output logic               multi
);

  logic [CW-1:0] cnt;

  // Count set bits and keep the index of the last one found
  always_comb begin
    cnt = '0;
    idx = '0;
    for (int i = 0; i < N_BANKS; i++) begin
      if (cs[i]) begin
        cnt = cnt + CW'(1);
        idx = BW'(i);
      end
    end
  end

  assign onehot_ok = (cnt == CW'(1));
  assign multi     = (cnt >  CW'(1));

endmodule

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: T1/T2/TW/T3/T4 bus-cycle controller with bank strobes.
// Define BUS_TIMEOUT_EN to add the T3 ready timeout and timeout_err.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int   N_BANKS        = 4,
  parameter int   WAIT_STATES    = 2,
  parameter logic VALID_IOM      = DEF_VALID_IOM,
  parameter int   TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iom,
  input  logic               rd_n,
  input  logic               wr_n,
  input  logic               ale,
  input  logic [N_BANKS-1:0] cs,
  input  logic               ready,
  output logic [N_BANKS-1:0] oe_n,
  output logic [N_BANKS-1:0] wd_n,
  output logic               load_address,
  output logic               busy,
`ifdef BUS_TIMEOUT_EN
  output logic               timeout_err,
`endif
  output logic               bank_err
);

  localparam int BW = $clog2(N_BANKS);

  localparam logic [3:0] WS_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

`ifdef BUS_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CYCLES - 1);
  logic [TCW-1:0] tcnt;
`endif

  state_t          state;
  dir_t            dir;
  logic [BW-1:0]   bank;
  logic [3:0]      wcnt;

  logic [BW-1:0]      dec_idx;
  logic               dec_ok;
  logic               dec_multi;
  logic               qual;
  logic               start;
  logic [N_BANKS-1:0] bank_sel;
  logic [N_BANKS-1:0] oe_hold;
  logic [N_BANKS-1:0] wd_hold;

  cs_decoder #(
    .N_BANKS (N_BANKS)
  ) u_dec (
    .cs        (cs),
    .idx       (dec_idx),
    .onehot_ok (dec_ok),
    .multi     (dec_multi)
  );

  assign qual     = ale && (iom == VALID_IOM);
  assign start    = qual && dec_ok;
  assign bank_sel = N_BANKS'(1) << bank;
  assign oe_hold  = (dir == DIR_READ)  ? ~bank_sel : '1;
  assign wd_hold  = (dir == DIR_WRITE) ? ~bank_sel : '1;

  // Bus FSM; strobes and flags are registered with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= T1;
      dir          <= DIR_READ;
      bank         <= '0;
      wcnt         <= '0;
      oe_n         <= '1;
      wd_n         <= '1;
      load_address <= 1'b0;
      busy         <= 1'b0;
      bank_err     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      tcnt         <= '0;
      timeout_err  <= 1'b0;
`endif
    end else begin
      load_address <= 1'b0;
      bank_err     <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      timeout_err  <= 1'b0;
`endif
      unique case (1'b1)
        state[S_T1]: begin
          if (start) begin
            state        <= T2;
            bank         <= dec_idx;
            load_address <= 1'b1;
            busy         <= 1'b1;
          end else if (qual && dec_multi) begin
            bank_err <= 1'b1;
          end
        end
        state[S_T2]: begin
          if (!rd_n || !wr_n) begin
            dir  <= rd_n ? DIR_WRITE : DIR_READ;
            oe_n <= rd_n ? '1 : ~bank_sel;
            wd_n <= rd_n ? ~bank_sel : '1;
`ifdef BUS_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (WAIT_STATES > 0) begin
              state <= TW;
              wcnt  <= WS_INIT;
            end else begin
              state <= T3;
            end
          end
        end
        state[S_TW]: begin
          oe_n <= oe_hold;
          wd_n <= wd_hold;
          if (wcnt == 4'd0) begin
            state <= T3;
`ifdef BUS_TIMEOUT_EN
            tcnt  <= '0;
`endif
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        state[S_T3]: begin
          if (ready) begin
            state <= T4;
            oe_n  <= '1;
            wd_n  <= '1;
`ifdef BUS_TIMEOUT_EN
          end else if (tcnt == T_LAST) begin
            state       <= T4;
            oe_n        <= '1;
            wd_n        <= '1;
            timeout_err <= 1'b1;
          end else begin
            tcnt <= tcnt + TCW'(1);
            oe_n <= oe_hold;
            wd_n <= wd_hold;
`else
          end else begin
            oe_n <= oe_hold;
            wd_n <= wd_hold;
`endif
          end
        end
        state[S_T4]: begin
          state <= T1;
          busy  <= 1'b0;
          oe_n  <= '1;
          wd_n  <= '1;
        end
        default: begin
          state <= T1;
          busy  <= 1'b0;
          oe_n  <= '1;
          wd_n  <= '1;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Parametrised bus-cycle controller for the local processor bus (T1/T2/T3/T4 protocol). It decodes N_BANKS one-hot chip selects and inserts programmable wait states. It also stretches cycles with a READY input, then drives per-bank active-low output-enable and write-strobe lines. It sits between the CPU bus pins and the memory/peripheral banks.

Parameters:
N_BANKS, 4, number of chip-select banks (2..16)
WAIT_STATES, 2, fixed TW cycles inserted per access (0..15)
VALID_IOM, 0, iom level that qualifies a memory cycle
TIMEOUT_CYCLES, 64, T3 ready-low limit (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
iom  in  1  memory/IO qualifier
rd_n  in  1  read request, active low
wr_n  in  1  write request, active low
ale  in  1  address latch enable
cs  in  N_BANKS  one-hot chip selects, active high
ready  in  1  target ready; low extends T3
oe_n  out  N_BANKS  per-bank output enable, active low
wd_n  out  N_BANKS  per-bank write strobe, active low
load_address  out  1  one-cycle address-latch pulse
busy  out  1  high whenever state != T1
bank_err  out  1  one-cycle pulse on illegal multi-bit cs

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). On reset: state=T1, oe_n and wd_n all ones, load_address=0, busy=0, bank_err=0, bank/dir/counter registers cleared. Reset mid-cycle deasserts strobes immediately.
- States (one-hot): T1, T2, TW, T3, T4. Outputs are Moore, decoded from registered state, bank index and direction.
- T1: start when ale=1 && iom==VALID_IOM && cs has exactly one bit set. Latch the bank index, assert load_address on that edge's next cycle (first T2 cycle only), then go to T2.
  - If cs has more than one bit set: bank_err=1 for one cycle, stay in T1.
  - If cs==0 or the qualifier fails: stay in T1 silently.
- T2: if rd_n=0, latch dir=READ. Else if wr_n=0, dir=WRITE. Read wins when both are low.
  - Next state is TW if WAIT_STATES>0 (counter=WAIT_STATES-1), else T3.
  - If neither request is low, hold in T2.
- TW: strobe of the latched bank asserted (oe_n[bank]=0 for read, wd_n[bank]=0 for write). Counter decrements each cycle; go to T3 when it is 0. ready is ignored in TW.
- T3: strobe still asserted. ready=1 goes to T4; ready=0 holds T3.
- T4: all strobes deasserted; go to T1 unconditionally. A new cycle can start in the following T1.
- Only the latched bank's strobe ever goes low. The other N_BANKS-1 bits stay 1, and oe_n/wd_n are never low together.
- Strobe width = WAIT_STATES+1+(extra ready-low T3 cycles).
- Inputs other than ready and rst_n are ignored outside T1/T2.

Optional Feature:
BUS_TIMEOUT_EN
- Defined: adds output timeout_err (1 bit, reset 0) and a T3 counter of consecutive ready=0 cycles. When it reaches TIMEOUT_CYCLES, the FSM forces T4 and timeout_err pulses high for that T4 cycle. The counter clears on entering T3.
- Undefined: no port and no counter; T3 waits indefinitely for ready.

Decomposition:
- Package mem_bus_ctrl_pkg: state enum (one-hot 5-bit T1,T2,TW,T3,T4), dir enum (READ, WRITE), and the default VALID_IOM constant.
- One sub-module, cs_decoder: combinational, parameterised by N_BANKS. Outputs are the binary bank index, onehot_ok (exactly one bit set) and multi (more than one bit set).
- The FSM, counters and output decode live in mem_bus_ctrl.

Test Plan:
- Reset: hold rst_n=0 mid-TW of a read on bank 2 -> oe_n=4'b1111 asynchronously, busy=0. After release, state T1.
- Read, WAIT_STATES=2, ready=1, cs=4'b0100, rd_n=0:
  - load_address=1 one cycle.
  - oe_n=4'b1011 for exactly 3 cycles; busy high 5 cycles (T2,TW,TW,T3,T4).
- Write on bank 0, ready low 4 cycles in T3 -> wd_n=4'b1110 held 3+4=7 cycles. oe_n stays 4'b1111 throughout.
- Contention: rd_n=0 and wr_n=0 together in T2 -> read performed, wd_n never low.
  - Separately, ale=1 with cs=4'b0110 -> bank_err one-cycle pulse, state stays T1, no strobes.
- Qualifier: ale=1, cs=4'b0001, iom=1 (VALID_IOM=0) -> no cycle, busy stays 0.
  - Back-to-back reads start in the T1 right after T4.
- BUS_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, ready tied 0 -> T3 lasts 8 cycles, then T4 with timeout_err=1 for one cycle, then strobes release.
